commit_trace_buf: RTL and testbench
===================================

# commit_trace_buf

Commit-trace capture buffer that sits directly downstream of the core top level and consumes its `pc_o`, `inst_o` and `nr_insts_o` outputs. It detects each retired instruction by watching the retired-instruction count advance, and pushes a `{seq, pc, inst}` record into an internal FIFO. The simulation harness or a debug port drains the FIFO through a valid/ready handshake. Overflow is counted rather than back-pressured, because the core has no stall input from this block.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `SEQ_W`, 16: width of the sequence tag, taken from the low bits of the retired count.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `pc_i` input 64: core `pc_o`.
- `inst_i` input 32: core `inst_o`.
- `nr_insts_i` input 64: core `nr_insts_o`, the retired-instruction count.
- `flush_i` input 1: synchronous clear of the FIFO and the drop counter.
- `out_valid_o` output 1: the head record is valid.
- `out_ready_i` input 1: the consumer accepts the head record.
- `out_seq_o` output SEQ_W: head record sequence tag.
- `out_pc_o` output 64: head record PC.
- `out_inst_o` output 32: head record instruction.
- `count_o` output $clog2(DEPTH)+1: current occupancy.
- `drop_cnt_o` output 16: number of records lost to a full FIFO; saturates at 16'hFFFF.
- `overflow_o` output 1: sticky; set on the first drop.
- `gap_o` output 1: sticky; set when the count advances by more than 1 in one cycle.

## Operation
- `prev_cnt` register holds the `nr_insts_i` value from the previous cycle. Its reset value is 0.
- Commit event: `nr_insts_i != prev_cnt`. `prev_cnt` updates every cycle.
- If `nr_insts_i - prev_cnt > 1` (64-bit unsigned subtraction), a single record is still pushed and `gap_o` is set.
- Record contents: `seq = nr_insts_i[SEQ_W-1:0]`, `pc = pc_i`, `inst = inst_i`. All are sampled in the event cycle.
- FIFO: circular buffer with read and write pointers of width $clog2(DEPTH)+1. The extra MSB distinguishes full from empty.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
- Push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- A push that is not accepted is a drop:
  - `drop_cnt_o` increments, saturating at 16'hFFFF.
  - `overflow_o` is set.
  - The record is discarded; existing entries are never overwritten.
- Pop occurs when `out_valid_o && out_ready_i`.
- Outputs are driven from the head entry. `out_valid_o = !empty`.
- Push and pop in the same cycle leave `count_o` unchanged. Both pointers advance and wrap modulo 2·DEPTH.
- `flush_i` has priority over push and pop in its cycle:
  - Pointers, `drop_cnt_o`, `overflow_o` and `gap_o` clear to 0.
  - `prev_cnt` still loads `nr_insts_i`, so no spurious event follows the flush.
- Reset values: `out_valid_o` 0, `count_o` 0, `drop_cnt_o` 0, `overflow_o` 0, `gap_o` 0. `out_seq_o`, `out_pc_o` and `out_inst_o` are 0 while the FIFO is empty.
- Reset asserted mid-operation discards all entries immediately; nothing drains afterwards.

## Timing
- Push to visibility is 1 cycle. A record pushed at edge N drives `out_valid_o` and the data outputs after edge N.
- Pop: the head advances at the edge where `out_valid_o && out_ready_i`. The next entry, or `out_valid_o` = 0, appears after that edge.
- Head data is stable while `out_valid_o && !out_ready_i`.
- Maximum sustained rate is one push and one pop per cycle.
- There are no combinational paths from `out_ready_i` to `out_valid_o`, `out_seq_o`, `out_pc_o` or `out_inst_o`. `count_o` is registered.

## Configuration
- `COMMIT_TRACE_NOP_FILTER_EN`
  - Defined: a commit event whose `inst_i == 32'h00000013` (canonical nop) is not pushed. It does not count as a drop, and `gap_o` detection is unaffected.
  - Undefined: every commit event is pushed.

## Test plan
- Reset release, then `nr_insts_i` 0→1 with `pc_i` = 64'h80000000 and `inst_i` = 32'h00100093 -> `out_valid_o` rises next cycle with seq 1, pc 64'h80000000, inst 32'h00100093, and `count_o` = 1.
- 20 consecutive commits with `out_ready_i` = 0 and DEPTH = 16 -> `count_o` = 16, `drop_cnt_o` = 4, `overflow_o` = 1. Draining then yields seq 1..16 in order.
- FIFO full and `out_ready_i` = 1 with a commit in the same cycle -> the record is accepted, `count_o` stays 16, and `drop_cnt_o` is unchanged.
- `nr_insts_i` jumps 5→8 -> one record with seq 8 is pushed and `gap_o` = 1. A subsequent `flush_i` -> `count_o` = 0, `gap_o` = 0, and no event occurs in the following cycle.
- `reset` asserted low with 7 entries queued -> `out_valid_o` and `count_o` go to 0 immediately, with no clock edge needed.
- With `COMMIT_TRACE_NOP_FILTER_EN` defined, commits of 32'h00000013, 32'h00200113 and 32'h00000013 -> exactly one record (inst 32'h00200113) and `drop_cnt_o` = 0. Without the macro, three records.

Source files
------------

// File: rtl/commit_trace_buf.sv
// Commit-trace capture FIFO: turns retired-count advances into {seq, pc, inst} records.
// Optional COMMIT_TRACE_NOP_FILTER_EN suppresses records for the canonical nop (32'h00000013).
module commit_trace_buf #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [63:0]              pc_i,
    input  logic [31:0]              inst_i,
    input  logic [63:0]              nr_insts_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [SEQ_W-1:0]         out_seq_o,
    output logic [63:0]              out_pc_o,
    output logic [31:0]              out_inst_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     overflow_o,
    output logic                     gap_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [63:0]      pc;
        logic [31:0]      inst;
    } rec_t;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [63:0]      prev_cnt_q, prev_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic             gap_q, gap_d;

    logic             empty, full, pop, push_req, push_ok, drop, commit_evt, gap_evt, is_nop;
    logic [63:0]      delta;
    rec_t             head, new_rec;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == {~rd_ptr_q[PTR_W-1], rd_ptr_q[IDX_W-1:0]});
    assign head  = mem[rd_ptr_q[IDX_W-1:0]];

    assign delta      = nr_insts_i - prev_cnt_q;
    assign commit_evt = (nr_insts_i != prev_cnt_q);
    assign gap_evt    = (delta > 64'd1);

`ifdef COMMIT_TRACE_NOP_FILTER_EN
    assign is_nop = (inst_i == NOP_INST);
`else
    assign is_nop = 1'b0;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop      = !empty && out_ready_i && !flush_i;
    assign push_req = commit_evt && !is_nop && !flush_i;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    assign new_rec = '{seq: nr_insts_i[SEQ_W-1:0], pc: pc_i, inst: inst_i};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        gap_d      = gap_q;
        prev_cnt_d = nr_insts_i;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
            gap_d      = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_ok && !pop)      count_d = count_q + PTR_ONE;
            else if (!push_ok && pop) count_d = count_q - PTR_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (gap_evt) gap_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prev_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            prev_cnt_q <= prev_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            gap_q      <= gap_d;
        end
    end

    // NOTE: the storage array is not reset; pointers define validity and outputs are gated while empty.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q[IDX_W-1:0]] <= new_rec;
    end

    assign out_valid_o = !empty;
    assign out_seq_o   = empty ? '0 : head.seq;
    assign out_pc_o    = empty ? '0 : head.pc;
    assign out_inst_o  = empty ? '0 : head.inst;
    assign count_o     = count_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = overflow_q;
    assign gap_o       = gap_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Scoreboard bench for commit_trace_buf: the stimulus side keeps a queue-based model of the
// trace FIFO, and a monitor compares every record the DUT hands out.
module tb_commit_trace_buf;

    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;
`ifdef COMMIT_TRACE_NOP_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [SEQ_W-1:0] seq;
        logic [63:0]      pc;
        logic [31:0]      inst;
    } rec_t;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [63:0]            pc_i = '0;
    logic [31:0]            inst_i = '0;
    logic [63:0]            nr_insts_i = '0;
    logic                   flush_i = 1'b0;
    logic                   out_valid_o;
    logic                   out_ready_i = 1'b0;
    logic [SEQ_W-1:0]       out_seq_o;
    logic [63:0]            out_pc_o;
    logic [31:0]            out_inst_o;
    logic [$clog2(DEPTH):0] count_o;
    logic [15:0]            drop_cnt_o;
    logic                   overflow_o;
    logic                   gap_o;

    commit_trace_buf #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clock(clock), .reset(reset), .pc_i(pc_i), .inst_i(inst_i), .nr_insts_i(nr_insts_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_seq_o(out_seq_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .count_o(count_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .gap_o(gap_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    rec_t        exp_q[$];
    logic [63:0] prev_m = '0;
    int          cnt_m = 0;
    int          drop_m = 0;
    bit          ov_m = 1'b0;
    bit          gap_m = 1'b0;
    logic [63:0] cur_nr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cnt_m  = 0;
        drop_m = 0;
        ov_m   = 1'b0;
        gap_m  = 1'b0;
    endtask

    // One cycle: check the DUT state left by the last edge, then drive inputs and advance the model.
    task automatic step(input logic [63:0] nr, input logic [63:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        bit pop, want, acc;
        @(negedge clock);
        check("count", 64'(count_o), 64'(cnt_m));
        check("valid", 64'(out_valid_o), 64'(cnt_m != 0));
        check("drop_cnt", 64'(drop_cnt_o), 64'(drop_m));
        check("overflow", 64'(overflow_o), 64'(ov_m));
        check("gap", 64'(gap_o), 64'(gap_m));

        nr_insts_i  = nr;
        pc_i        = pc;
        inst_i      = inst;
        flush_i     = fl;
        out_ready_i = fl ? 1'b0 : rdy;
        cur_nr      = nr;

        if (fl) begin
            model_clear();
        end else begin
            pop  = (cnt_m > 0) && rdy;
            want = (nr != prev_m) && !(FILT && inst == 32'h00000013);
            if (nr - prev_m > 64'd1) gap_m = 1'b1;
            acc = want && (cnt_m < DEPTH || pop);
            if (pop) cnt_m--;
            if (acc) begin
                cnt_m++;
                exp_q.push_back('{seq: nr[SEQ_W-1:0], pc: pc, inst: inst});
            end
            if (want && !acc) begin
                ov_m = 1'b1;
                if (drop_m < 65535) drop_m++;
            end
        end
        prev_m = nr;
    endtask

    task automatic idle(input logic rdy);
        step(cur_nr, 64'h0, 32'h0, rdy, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a record that is being accepted.
    initial begin
        rec_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset && out_valid_o && out_ready_i) begin
                check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rec_seq", 64'(out_seq_o), 64'(e.seq));
                    check("rec_pc", out_pc_o, e.pc);
                    check("rec_inst", 64'(out_inst_o), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        int r, rdy_pct, jump;
        logic [31:0] inst_r;

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_seq", 64'(out_seq_o), 64'd0);
        check("rst_pc", out_pc_o, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // First commit and its visibility one cycle later
        step(64'd1, 64'h80000000, 32'h00100093, 1'b0, 1'b0);
        idle(1'b0);
        check("t1_seq", 64'(out_seq_o), 64'd1);
        check("t1_pc", out_pc_o, 64'h80000000);
        check("t1_inst", 64'(out_inst_o), 64'h00100093);
        idle(1'b1);
        idle(1'b0);

        // 20 commits into a 16-deep FIFO with the consumer stalled
        for (int i = 0; i < 20; i++)
            step(cur_nr + 64'd1, 64'h80001000 + 64'(4 * i), 32'h00000093 | 32'(i << 20), 1'b0, 1'b0);
        idle(1'b0);
        check("ovf_count", 64'(count_o), 64'd16);
        check("ovf_drop", 64'(drop_cnt_o), 64'd4);
        check("ovf_flag", 64'(overflow_o), 64'd1);

        // Full FIFO, simultaneous pop and commit
        step(cur_nr + 64'd1, 64'h80002000, 32'h00300193, 1'b1, 1'b0);
        idle(1'b0);
        check("fullpp_count", 64'(count_o), 64'd16);
        check("fullpp_drop", 64'(drop_cnt_o), 64'd4);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // Gap detection, then flush
        step(cur_nr + 64'd3, 64'h80003000, 32'h00400213, 1'b0, 1'b0);
        idle(1'b0);
        check("gap_flag", 64'(gap_o), 64'd1);
        check("gap_seq", 64'(out_seq_o), 64'(cur_nr[SEQ_W-1:0]));
        step(cur_nr, 64'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_gap", 64'(gap_o), 64'd0);
        idle(1'b0);
        check("flush_noevt", 64'(count_o), 64'd0);

        // Asynchronous reset with 7 entries queued
        for (int i = 0; i < 7; i++)
            step(cur_nr + 64'd1, 64'h80004000 + 64'(4 * i), 32'h00500293, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        reset      = 1'b0;
        nr_insts_i = '0;
        cur_nr     = '0;
        #1;
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_count", 64'(count_o), 64'd0);
        model_clear();
        prev_m = '0;
        @(negedge clock);
        reset = 1'b1;

        // Nop filtering
        step(64'd1, 64'h80005000, 32'h00000013, 1'b0, 1'b0);
        step(64'd2, 64'h80005004, 32'h00200113, 1'b0, 1'b0);
        step(64'd3, 64'h80005008, 32'h00000013, 1'b0, 1'b0);
        idle(1'b0);
        check("nop_count", 64'(count_o), FILT ? 64'd1 : 64'd3);
        check("nop_drop", 64'(drop_cnt_o), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Randomized traffic with varying consumer pressure
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            r = $urandom_range(0, 99);
            if (r < 55)      jump = 1;
            else if (r < 90) jump = 0;
            else             jump = $urandom_range(2, 4);
            inst_r = ($urandom_range(0, 7) == 0) ? 32'h00000013 : $urandom;
            step(cur_nr + 64'(jump), {$urandom, $urandom}, inst_r,
                 ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 299) == 0));
        end

        for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
        idle(1'b0);
        check("end_sb_empty", 64'(exp_q.size()), 64'd0);
        check("end_count", 64'(count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
